// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit positions and the serial state encoding
// used by both the transmit and receive sequencers of mmio_uart.
package mmio_uart_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;

   localparam int ST_TX_FULL      = 0;
   localparam int ST_TX_EMPTY     = 1;
   localparam int ST_TX_BUSY      = 2;
   localparam int ST_RX_AVAIL     = 3;
   localparam int ST_RX_OVERRUN   = 4;
   localparam int ST_TX_DROP      = 5;
   localparam int ST_RX_FRAME_ERR = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB wrap pointers; a push on a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; only the pointers decide what is visible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART on the core data bus: DATA/STATUS registers with
// BRAM-like one-cycle registered reads, TX and RX FIFOs, inline serial FSMs.
module mmio_uart
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] adr,
   input  logic [31:0] writedata,
   input  logic        memwrite,
   input  logic        re,
   output logic [31:0] readdata,
   output logic        hit_q,
   output logic        txd,
   input  logic        rxd
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic        hit;
   logic [1:0]  off;
   logic        status_wr;
   logic [31:0] status;
   logic [31:0] rd_mux;
   logic        unused_bits;

   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]  tx_head;
   uart_state_t tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;

   logic        rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]  rx_head;
   logic [1:0]  rx_sync;
   logic        rx_s;
   uart_state_t rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_stop_sample;

   logic        rx_overrun, tx_drop, rx_frame_err;

   assign hit         = (adr[31:4] == BASE_ADDR[31:4]);
   assign off         = adr[3:2];
   assign status_wr   = hit & memwrite & (off == OFF_STATUS);
   assign unused_bits = ^{adr[1:0], writedata[31:8]};

   assign tx_push = hit & memwrite & (off == OFF_DATA);
   assign tx_pop  = (tx_state == IDLE) & ~tx_empty;
   assign rx_pop  = hit & re & ~memwrite & (off == OFF_DATA) & ~rx_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (writedata[7:0]),
      .pop   (tx_pop),
      .head  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .din   (rx_shift),
      .pop   (rx_pop),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      status                  = '0;
      status[ST_TX_FULL]      = tx_full;
      status[ST_TX_EMPTY]     = tx_empty;
      status[ST_TX_BUSY]      = (tx_state != IDLE);
      status[ST_RX_AVAIL]     = ~rx_empty;
      status[ST_RX_OVERRUN]   = rx_overrun;
      status[ST_TX_DROP]      = tx_drop;
      status[ST_RX_FRAME_ERR] = rx_frame_err;
   end

   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_DATA:   rd_mux = rx_empty ? 32'h0 : {24'h0, rx_head};
         OFF_STATUS: rd_mux = status;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         readdata <= '0;
         hit_q    <= 1'b0;
      end else begin
         readdata <= hit ? rd_mux : 32'h0;
         hit_q    <= hit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         txd      <= 1'b1;
      end else begin
         case (tx_state)
            IDLE: begin
               txd    <= 1'b1;
               tx_cnt <= '0;
               if (!tx_empty) begin
                  tx_shift <= tx_head;
                  txd      <= 1'b0;
                  tx_state <= START;
               end
            end
            START: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  txd      <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_state <= DATA;
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
               end
            end
            DATA: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     txd      <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     txd      <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
               end
            end
            STOP: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= IDLE;
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_sync <= 2'b11;
      else     rx_sync <= {rx_sync[0], rxd};
   end
   assign rx_s = rx_sync[1];

   assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == CNT_LAST);
   assign rx_push        = rx_stop_sample & rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            IDLE: begin
               rx_cnt <= '0;
               if (!rx_s) rx_state <= START;
            end
            START: begin
               if (rx_cnt == CNT_HALF) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s ? IDLE : DATA;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            DATA: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            STOP: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= IDLE;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

   // Sticky flags: a new event in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_overrun   <= 1'b0;
         tx_drop      <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (status_wr && writedata[ST_RX_OVERRUN])   rx_overrun   <= 1'b0;
         if (status_wr && writedata[ST_TX_DROP])      tx_drop      <= 1'b0;
         if (status_wr && writedata[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
         if (rx_push && rx_full && !rx_pop)           rx_overrun   <= 1'b1;
         if (tx_push && tx_full && !tx_pop)           tx_drop      <= 1'b1;
         if (rx_stop_sample && !rx_s)                 rx_frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mmio_uart.sv
// Self-checking bench for mmio_uart: decode table, TX/RX scoreboards and
// hand-written sequences for overflow, overrun, framing, held reads and reset.
module tb_mmio_uart;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] adr = '0;
   logic [31:0] writedata = '0;
   logic        memwrite = 1'b0;
   logic        re = 1'b0;
   logic [31:0] readdata;
   logic        hit_q;
   logic        txd;
   logic        rxd = 1'b1;

   int total = 0;
   int bad   = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic       mon_abort = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic        r;
      logic        exp_hit;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   mmio_uart #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .adr       (adr),
      .writedata (writedata),
      .memwrite  (memwrite),
      .re        (re),
      .readdata  (readdata),
      .hit_q     (hit_q),
      .txd       (txd),
      .rxd       (rxd)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      adr = a; writedata = d; memwrite = 1'b1; re = 1'b0;
      @(negedge clk);
      memwrite = 1'b0; adr = 32'h0;
   endtask

   task automatic rd(input logic [31:0] a, input logic r, output logic [31:0] d, output logic h);
      @(negedge clk);
      adr = a; re = r; memwrite = 1'b0;
      @(negedge clk);
      d = readdata; h = hit_q;
      re = 1'b0; adr = 32'h0;
   endtask

   task automatic check_status(input string name, input logic [31:0] exp);
      logic [31:0] d;
      logic        h;
      rd(BASE + 32'h4, 1'b0, d, h);
      check(name, d, exp);
   endtask

   task automatic rx_pop_check(input string name);
      logic [31:0] d;
      logic        h;
      rd(BASE, 1'b1, d, h);
      if (rx_q.size() == 0) check(name, d, 32'h0);
      else                  check(name, d, {24'h0, rx_q.pop_front()});
   endtask

   // Drives one 8N1 frame plus one idle bit; the model keeps what a DEPTH-deep FIFO would hold.
   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rxd = frame[i];
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk);
      rxd = 1'b1;
      repeat (CPB - 1) @(negedge clk);
      if (stop_bit && rx_q.size() < DEPTH) rx_q.push_back(b);
   endtask

   task automatic wait_tx_drain(input int max_cycles);
      int n;
      n = 0;
      while (tx_q.size() != 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("tx_drain", 32'(tx_q.size()), 32'h0);
      repeat (8) @(negedge clk);
   endtask

   always @(posedge rst) mon_abort = 1'b1;

   // TX monitor: decodes each frame at mid-bit samples and compares with the scoreboard.
   initial begin
      logic [7:0] b;
      logic       start_ok;
      logic       stop_v;
      forever begin
         @(negedge clk);
         if (!rst && txd === 1'b0) begin
            mon_abort = 1'b0;
            b = '0;
            repeat (2) @(negedge clk);
            start_ok = (txd === 1'b0);
            repeat (3) @(negedge clk);
            b[0] = txd;
            for (int k = 1; k < 8; k++) begin
               repeat (CPB) @(negedge clk);
               b[k] = txd;
            end
            repeat (CPB) @(negedge clk);
            stop_v = txd;
            if (!mon_abort) begin
               if (tx_q.size() == 0) check("tx_frame_expected", 32'h0, 32'h1);
               else check("tx_frame", {22'h0, start_ok, stop_v, b},
                          {22'h0, 1'b1, 1'b1, tx_q.pop_front()});
            end
         end
      end
   end

   initial begin
      logic [31:0] d;
      logic        h;
      logic [7:0]  pat;
      int          errs;
      int          lows;
      logic        found;

      vecs[0] = '{BASE + 32'h0,  1'b1, 1'b1, 32'h0};
      vecs[1] = '{BASE + 32'h4,  1'b0, 1'b1, 32'h2};
      vecs[2] = '{32'h0000_1000, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{BASE + 32'h8,  1'b0, 1'b1, 32'h0};
      vecs[4] = '{BASE + 32'h4,  1'b1, 1'b1, 32'h2};
      vecs[5] = '{BASE + 32'hC,  1'b0, 1'b1, 32'h0};
      vecs[6] = '{BASE + 32'h10, 1'b0, 1'b0, 32'h0};

      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_readdata", readdata, 32'h0);
      check("rst_hit_q", {31'h0, hit_q}, 32'h0);
      check("rst_txd", {31'h0, txd}, 32'h1);
      rst = 1'b0;

      wr(BASE + 32'h8, 32'hFF);
      wr(BASE + 32'hC, 32'hFF);
      for (int i = 0; i < 7; i++) begin
         rd(vecs[i].a, vecs[i].r, d, h);
         check($sformatf("vec%0d_hit_q", i), {31'h0, h}, {31'h0, vecs[i].exp_hit});
         check($sformatf("vec%0d_readdata", i), d, vecs[i].exp_data);
      end

      // Single TX frame: exact waveform plus busy flag mid-frame.
      pat = 8'h55;
      tx_q.push_back(pat);
      wr(BASE, {24'h0, pat});
      errs  = 0;
      found = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (txd === 1'b0) begin
                  found = 1'b1;
                  break;
               end
            end
            for (int i = 0; i < 40; i++) begin
               if (i > 0) @(negedge clk);
               if (i < CPB) begin
                  if (txd !== 1'b0) errs++;
               end else if (i < 9 * CPB) begin
                  if (txd !== pat[(i - CPB) / CPB]) errs++;
               end else begin
                  if (txd !== 1'b1) errs++;
               end
            end
         end
         begin
            repeat (12) @(negedge clk);
            rd(BASE + 32'h4, 1'b0, d, h);
            check("tx_busy_mid_frame", {31'h0, d[2]}, 32'h1);
         end
      join
      check("tx_start_seen", {31'h0, found}, 32'h1);
      check("tx_waveform_errs", 32'(errs), 32'h0);
      wait_tx_drain(200);
      check_status("tx_idle_status", 32'h02);

      // Single RX frame read back through DATA.
      send_rx(8'hA5, 1'b1);
      check_status("rx_avail_status", 32'h0A);
      rx_pop_check("rx_a5");
      check_status("rx_drained_status", 32'h02);

      // TX overflow: one byte in the shifter, four queued, sixth dropped.
      for (int i = 0; i < 6; i++) begin
         if (i < 5) tx_q.push_back(8'h11 + 8'(i));
         wr(BASE, 32'h11 + 32'(i));
      end
      check_status("tx_overflow_status", 32'h25);
      wr(BASE + 32'h4, 32'h20);
      check_status("tx_drop_cleared", 32'h05);
      wait_tx_drain(600);
      check_status("tx_overflow_drained", 32'h02);

      // RX overrun, in-order contents, then a framing error that pushes nothing.
      for (int i = 0; i < 5; i++) send_rx(8'h31 + 8'(i), 1'b1);
      check_status("rx_overrun_status", 32'h1A);
      for (int i = 0; i < DEPTH; i++) rx_pop_check($sformatf("rx_overrun_pop%0d", i));
      send_rx(8'h36, 1'b0);
      check_status("rx_frame_err_status", 32'h52);
      wr(BASE + 32'h4, 32'h70);
      check_status("rx_flags_cleared", 32'h02);

      // Held DATA address with re only on the first cycle pops exactly once.
      send_rx(8'h41, 1'b1);
      send_rx(8'h42, 1'b1);
      @(negedge clk);
      adr = BASE; re = 1'b1; memwrite = 1'b0;
      @(negedge clk);
      re = 1'b0;
      check("hold_first", readdata, {24'h0, rx_q.pop_front()});
      repeat (9) @(negedge clk);
      check("hold_last", readdata, {24'h0, rx_q[0]});
      check("hold_hit_q", {31'h0, hit_q}, 32'h1);
      adr = 32'h0;
      check_status("hold_one_left", 32'h0A);
      rx_pop_check("hold_remaining");
      check_status("hold_drained", 32'h02);

      // Reset mid-frame: line returns high immediately and the frame does not resume.
      tx_q.push_back(8'h00);
      wr(BASE, 32'h00);
      repeat (15) @(negedge clk);
      check("txd_low_before_rst", {31'h0, txd}, 32'h0);
      rst = 1'b1;
      #1;
      check("txd_high_in_rst", {31'h0, txd}, 32'h1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tx_q.delete();
      check_status("post_rst_status", 32'h02);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("post_rst_txd_idle", 32'(lows), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
